argmax_classifier: RTL and testbench
====================================

// Module: argmax_classifier
// PURPOSE
//  Final stage of the BNN pipeline; sits directly downstream of the output neurons.
//  Consumes one output-neuron popcount per beat, class order 0..NUM_CLASSES-1.
//  Tracks the running maximum and emits the winning class index once per frame.
//  Result is held on a valid/ready handshake until the downstream consumer takes it.
// PARAMETERS
//  NUM_CLASSES  10               number of output neurons (beats) per frame, >=2
//  THRESH_W     16               popcount width, matches the output neuron's popcount_out
//  IDX_W        $clog2(NUM_CLASSES)  class index width (derived, do not override)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  in_valid     in   1         popcount beat valid (driven by neuron valid_out)
//  in_ready     out  1         stage can accept a beat
//  in_popcount  in   THRESH_W  unsigned popcount of class = current beat count
//  in_last      in   1         producer's end-of-frame marker, checked only
//  out_valid    out  1         class result valid
//  out_ready    in   1         consumer accepts result
//  out_class    out  IDX_W     index of max popcount
//  frame_err    out  1         sticky: in_last disagreed with beat count
//  out_score    out  THRESH_W  max popcount (only with ARGMAX_SCORE_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=ACCUM, cnt=0, max=0, out_valid=0, out_class=0,
//    frame_err=0, out_score=0, in_ready=1 after release. A partial frame is discarded.
//  - States: ACCUM (in_ready=1, out_valid=0), DONE (in_ready=0, out_valid=1).
//  - Beat accepted iff in_valid && in_ready; no other input is sampled.
//  - cnt==0 beat: max<=in_popcount, idx<=0 unconditionally.
//  - cnt>0 beat: if in_popcount > max (strict, unsigned), max<=in_popcount, idx<=cnt.
//    Ties keep the lower index.
//  - Accepted beat with cnt==NUM_CLASSES-1: include the beat in the compare, cnt<=0,
//    next state DONE. out_valid=1 and out_class are registered the cycle after this beat.
//  - DONE: out_class/out_score are stable while out_valid && !out_ready.
//    On out_valid && out_ready: next state ACCUM; in_ready rises the following cycle.
//    No same-cycle bypass.
//  - Throughput: NUM_CLASSES + 1 cycles per frame when out_ready is held high.
//  - cnt wraps NUM_CLASSES-1 -> 0 only on frame end; it never exceeds NUM_CLASSES-1.
//  - frame_err is set (sticky until reset) by either of:
//    * an accepted beat with in_last=1 and cnt != NUM_CLASSES-1;
//    * an accepted final beat with in_last=0.
//    The frame still completes by count; frame_err does not alter the result.
//  - Bubbles (in_valid=0) mid-frame: state, cnt and max hold.
//  - Popcount 0 and all-ones (2^THRESH_W-1) are legal; compare is full width, no saturation.
// CONFIGURATION
//  - ARGMAX_SCORE_EN defined: out_score is present and carries the max popcount,
//    registered alongside out_class with the same hold rules.
//  - ARGMAX_SCORE_EN undefined: the out_score port and its register do not exist;
//    all other behaviour is identical.
// TESTING
//  1. NUM_CLASSES=10, beats 3,9,1,0,4,2,8,7,5,6, out_ready=1 -> 1 cycle after beat 10:
//     out_valid=1, out_class=1, out_score=9.
//  2. Tie: beats 5,5,...,5 -> out_class=0; beats 2,7,7,1,... (others <7) -> out_class=1.
//  3. Backpressure: out_ready=0 for 5 cycles after the result -> out_valid and out_class
//     stable, in_ready=0; new beats are ignored. out_ready=1 -> in_ready=1 next cycle.
//  4. Bubbles: in_valid toggled 1/0 across a frame -> same result as the gap-free frame.
//     Back-to-back frames: second result correct, not contaminated by the first max.
//  5. in_last on beat 4 of 10 -> frame_err=1 and stays 1; frame completes after beat 10
//     with the correct class.
//  6. rst_n low mid-frame (after beat 6) -> all outputs 0 immediately. The next full frame
//     gives the correct class; 65535 in slot 9 -> out_class=9.

Source files
------------

// File: rtl/argmax_classifier.sv
// -----------------------------------------------------------------------------
// argmax_classifier
//   Final stage of the BNN pipeline. Takes one output-neuron popcount per beat,
//   in class order 0..NUM_CLASSES-1, tracks the running maximum and presents
//   the winning class index once per frame on a valid/ready handshake.
//
//   Optional feature macro: ARGMAX_SCORE_EN
//     defined   -> out_score port exists and carries the winning popcount
//     undefined -> no out_score port and no score register
//
// Ports
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   in_valid     in   1         popcount beat valid
//   in_ready     out  1         stage can accept a beat (ACCUM state)
//   in_popcount  in   THRESH_W  unsigned popcount of class = beat count
//   in_last      in   1         producer end-of-frame marker (checked only)
//   out_valid    out  1         class result valid (DONE state)
//   out_ready    in   1         consumer accepts result
//   out_class    out  IDX_W     index of the maximum popcount
//   frame_err    out  1         sticky: in_last disagreed with the beat count
//   out_score    out  THRESH_W  maximum popcount (ARGMAX_SCORE_EN only)
// -----------------------------------------------------------------------------
module argmax_classifier #(
  parameter  int NUM_CLASSES = 10,
  parameter  int THRESH_W    = 16,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [THRESH_W-1:0] in_popcount,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_class,
  output logic                frame_err
`ifdef ARGMAX_SCORE_EN
  ,
  output logic [THRESH_W-1:0] out_score
`endif
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [THRESH_W-1:0]   r_max;
  logic [IDX_W-1:0]      r_class;
  logic                  r_frame_err;
`ifdef ARGMAX_SCORE_EN
  logic [THRESH_W-1:0]   r_score;
`endif

  logic                  w_accept;
  logic                  w_final;
  logic [THRESH_W-1:0]   w_max_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;

  // The first beat of a frame seeds the running max unconditionally, so the
  // previous frame's max can never leak into this one. Later beats replace it
  // only on a strict win, which keeps the lower index on ties.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_max_nxt = r_max;
    w_idx_nxt = r_idx;
    if (r_cnt == '0) begin
      w_max_nxt = in_popcount;
      w_idx_nxt = '0;
    end else if (in_popcount > r_max) begin
      w_max_nxt = in_popcount;
      w_idx_nxt = r_cnt;
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_final  = (r_cnt == LAST_IDX);

  // in_ready is gated by rst_n so the stage reports not-ready while held in reset.
  assign in_ready  = rst_n && (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_DONE);
  assign out_class = r_class;
  assign frame_err = r_frame_err;
`ifdef ARGMAX_SCORE_EN
  assign out_score = r_score;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_class     <= '0;
      r_frame_err <= 1'b0;
`ifdef ARGMAX_SCORE_EN
      r_score     <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_max <= w_max_nxt;
            r_idx <= w_idx_nxt;
            // in_last is only cross-checked; the frame always ends by count.
            if (in_last != w_final) begin
              r_frame_err <= 1'b1;
            end
            if (w_final) begin
              r_cnt   <= '0;
              r_class <= w_idx_nxt;
`ifdef ARGMAX_SCORE_EN
              r_score <= w_max_nxt;
`endif
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          // No bypass: in_ready returns only the cycle after the handshake.
          if (out_ready) begin
            r_state <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_argmax_classifier
//   Directed bench for argmax_classifier (NUM_CLASSES=10, THRESH_W=16).
//   The driver pushes the hand-computed result of each frame into a queue;
//   a monitor pops and compares whenever a result handshake occurs.
// -----------------------------------------------------------------------------
module tb_argmax_classifier;

  localparam int NC = 10;
  localparam int TW = 16;
  localparam int IW = $clog2(NC);

  typedef int frame_t[NC];
  typedef struct {
    int cls;
    int score;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_popcount;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic          frame_err;
`ifdef ARGMAX_SCORE_EN
  logic [TW-1:0] out_score;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_results = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  argmax_classifier #(.NUM_CLASSES(NC), .THRESH_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_popcount (in_popcount),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
    .frame_err   (frame_err)
`ifdef ARGMAX_SCORE_EN
    ,
    .out_score   (out_score)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on any cycle with out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_results++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_class), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_class", 32'(out_class), 32'(e.cls));
`ifdef ARGMAX_SCORE_EN
        check("out_score", 32'(out_score), 32'(e.score));
`endif
      end
    end
  end

  task automatic expect_result(input int cls, input int score);
    exp_t e;
    e.cls   = cls;
    e.score = score;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Drive nbeats beats of v; in_last on index last_pos; optional bubble cycles.
  task automatic send_beats(input frame_t v, input int last_pos, input bit bubbles, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      wait_ready();
      in_valid    = 1'b1;
      in_popcount = TW'(v[i]);
      in_last     = (i == last_pos);
      @(posedge clk); #1;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      if (bubbles && i < nbeats - 1) begin
        in_popcount = 16'hFFFF;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f1 = '{3, 9, 1, 0, 4, 2, 8, 7, 5, 6};
    frame_t f2 = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    frame_t f3 = '{2, 7, 7, 1, 0, 3, 6, 5, 4, 2};
    frame_t f4 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    frame_t f6 = '{1, 2, 0, 3, 0, 0, 0, 0, 0, 0};
    frame_t f7 = '{4, 4, 4, 4, 6, 1, 1, 1, 1, 1};
    frame_t f8 = '{65535, 0, 1, 2, 3, 4, 5, 65535, 6, 7};
    frame_t fp = '{100, 100, 60000, 100, 100, 100, 0, 0, 0, 0};
    frame_t f9 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 65535};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_popcount = '0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic frame: result registered one cycle after the last beat.
    expect_result(1, 9);
    send_beats(f1, 9, 1'b0, NC);
    check("f1_out_valid", 32'(out_valid), 32'd1);
    check("f1_in_ready", 32'(in_ready), 32'd0);

    // Ties keep the lower index.
    expect_result(0, 5);
    send_beats(f2, 9, 1'b0, NC);
    expect_result(1, 7);
    send_beats(f3, 9, 1'b0, NC);

    // Backpressure: result held, junk beats ignored.
    wait_ready();
    out_ready = 1'b0;
    expect_result(9, 1);
    send_beats(f4, 9, 1'b0, NC);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_class", 32'(out_class), 32'd9);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid    = 1'b1;
      in_popcount = 16'hFFFF;
      in_last     = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("bp_frame_err", 32'(frame_err), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Bubbles give the same result; next frame not contaminated by max 9.
    expect_result(1, 9);
    send_beats(f1, 9, 1'b1, NC);
    expect_result(3, 3);
    send_beats(f6, 9, 1'b0, NC);

    // All-ones popcount, tie at full width.
    expect_result(0, 65535);
    send_beats(f8, 9, 1'b0, NC);
    check("pre_err_frame_err", 32'(frame_err), 32'd0);

    // Early in_last: sticky error, frame still completes by count.
    expect_result(4, 6);
    send_beats(f7, 3, 1'b0, NC);
    check("err_frame_err", 32'(frame_err), 32'd1);
    check("err_out_class", 32'(out_class), 32'd4);

    // Partial frame, then asynchronous reset mid-frame.
    send_beats(fp, -1, 1'b0, 6);
    check("partial_frame_err", 32'(frame_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_class", 32'(out_class), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    expect_result(9, 65535);
    send_beats(f9, 9, 1'b0, NC);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(n_results), 32'd9);
    check("final_frame_err", 32'(frame_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
